keypad_scan_ctrl: RTL and testbench

- Sequences a 4x4 matrix keypad using the periodic single-cycle tick from the keypad tick generator.
- Drives one row low per tick, samples the columns and debounces across whole scan frames.
- Delivers each key press as a 4-bit code with a valid/ack handshake to the keypad Wishbone slave.
- Sits between the tick generator and the bus register file.

---
 rtl/keypad_scan_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// keypad_scan_ctrl: 4x4 keypad row scanner with frame debouncing and a valid/ack key event output.
// Optional auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scan_ctrl #(
  parameter int DEBOUNCE = 3
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       scan_tick,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_pressed,
  output logic       overrun
);

  localparam logic [0:0] ST_SCAN = 1'b0;
  localparam logic [0:0] ST_EVAL = 1'b1;
  localparam logic [3:0] c_DEBOUNCE = 4'(DEBOUNCE);

  logic [3:0]  r_col_s1;
  logic [3:0]  r_col_s2;
  logic [0:0]  r_state;
  logic [1:0]  r_row_idx;
  logic        r_tick_pend;
  logic [15:0] r_frame;
  // Candidates and the stable state are {valid, code}; 5'd0 means "no key".
  logic [4:0]  r_prev_cand;
  logic [3:0]  r_db_cnt;
  logic [4:0]  r_stable;
  logic [3:0]  r_row_out;
  logic [3:0]  r_key_code;
  logic        r_key_valid;
  logic        r_key_pressed;
  logic        r_overrun;

  logic        w_tick;
  logic [1:0]  w_nhits;
  logic [3:0]  w_hit_idx;
  logic [4:0]  w_cand;
  logic [3:0]  w_cnt_next;
  logic        w_accept;
  logic        w_eval;
  logic        w_press_ev;
  logic        w_rep_ev;
  logic        w_event;
  logic [3:0]  w_ev_code;
  logic        w_ack;
  logic [3:0]  w_row_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= col_in;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_tick     = scan_tick | r_tick_pend;
  assign w_row_base = {r_row_idx, 2'b00};

  // Hit count saturates at 2: anything above one hit is treated identically.
  always_comb begin
    w_nhits   = 2'd0;
    w_hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_frame[i]) begin
        if (w_nhits != 2'd2) w_nhits = w_nhits + 2'd1;
        w_hit_idx = 4'(i);
      end
    end
  end

  assign w_cand     = (w_nhits == 2'd1) ? {1'b1, w_hit_idx} : 5'd0;
  assign w_cnt_next = (w_cand != r_prev_cand) ? 4'd1 :
                      (r_db_cnt >= c_DEBOUNCE) ? c_DEBOUNCE : r_db_cnt + 4'd1;
  assign w_accept   = (w_cnt_next == c_DEBOUNCE) && (w_cand != r_stable);
  assign w_eval     = en && (r_state == ST_EVAL);
  assign w_press_ev = w_eval && w_accept && w_cand[4];
  assign w_event    = w_press_ev | w_rep_ev;
  assign w_ev_code  = w_press_ev ? w_cand[3:0] : r_stable[3:0];
  assign w_ack      = key_ack & r_key_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_SCAN;
      r_row_idx     <= 2'd0;
      r_tick_pend   <= 1'b0;
      r_frame       <= 16'd0;
      r_prev_cand   <= 5'd0;
      r_db_cnt      <= 4'd0;
      r_stable      <= 5'd0;
      r_key_pressed <= 1'b0;
      r_row_out     <= 4'b1110;
    end else if (!en) begin
      r_state       <= ST_SCAN;
      r_row_idx     <= 2'd0;
      r_tick_pend   <= 1'b0;
      r_frame       <= 16'd0;
      r_prev_cand   <= 5'd0;
      r_db_cnt      <= 4'd0;
      r_stable      <= 5'd0;
      r_key_pressed <= 1'b0;
      r_row_out     <= 4'b1111;
    end else begin
      r_row_out <= ~(4'b0001 << r_row_idx);
      case (r_state)
        ST_SCAN: begin
          if (w_tick) begin
            r_tick_pend               <= 1'b0;
            r_frame[w_row_base +: 4]  <= r_frame[w_row_base +: 4] | ~r_col_s2;
            r_row_idx                 <= r_row_idx + 2'd1;
            if (r_row_idx == 2'd3) r_state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          // A tick landing here is replayed on row 0 in the following cycle.
          r_tick_pend <= scan_tick;
          r_frame     <= 16'd0;
          r_prev_cand <= w_cand;
          r_db_cnt    <= w_cnt_next;
          if (w_accept) begin
            r_stable      <= w_cand;
            r_key_pressed <= w_cand[4];
          end
          r_state <= ST_SCAN;
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_event) begin
      if (!r_key_valid || w_ack) begin
        r_key_code  <= w_ev_code;
        r_key_valid <= 1'b1;
        r_overrun   <= 1'b0;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_ack) begin
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0] c_REP_DELAY = 8'(REPEAT_DELAY);
  localparam logic [7:0] c_REP_RATE  = 8'(REPEAT_RATE);

  logic [7:0] r_rep_cnt;
  logic       r_rep_armed;
  logic [7:0] w_rep_cnt_next;

  assign w_rep_cnt_next = r_rep_cnt + 8'd1;
  assign w_rep_ev = w_eval && !w_accept && r_stable[4] &&
                    (w_rep_cnt_next == (r_rep_armed ? c_REP_RATE : c_REP_DELAY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt   <= 8'd0;
      r_rep_armed <= 1'b0;
    end else if (!en) begin
      r_rep_cnt   <= 8'd0;
      r_rep_armed <= 1'b0;
    end else if (w_eval) begin
      if (w_accept) begin
        r_rep_cnt   <= 8'd0;
        r_rep_armed <= 1'b0;
      end else if (r_stable[4]) begin
        if (w_rep_ev) begin
          r_rep_cnt   <= 8'd0;
          r_rep_armed <= 1'b1;
        end else begin
          r_rep_cnt <= w_rep_cnt_next;
        end
      end
    end
  end
`else
  assign w_rep_ev = 1'b0;
`endif

  assign row_out     = r_row_out;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_pressed = r_key_pressed;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// tb_keypad_scan_ctrl: directed vector table, hand sequences and random frames against a frame-level model.
module tb_keypad_scan_ctrl;

  localparam int DB = 3;
  localparam int TP = 8;

  logic       clk = 1'b0;
  logic       rst_n, en, scan_tick, key_ack;
  logic [3:0] col_in, row_out, key_code;
  logic       key_valid, key_pressed, overrun;
  logic [15:0] keys;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference state; -1 means "no key".
  int   m_prev, m_cnt, m_stable;
  logic m_pressed, m_valid, m_ovr;
  logic [3:0] m_code;

  typedef struct {
    logic [15:0] mask;
    bit          ack_eval;
    bit          ack_after;
    logic        v;
    logic [3:0]  c;
    logic        p;
    logic        o;
  } vec_t;
  vec_t vecs[$];

  keypad_scan_ctrl #(.DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .scan_tick(scan_tick), .col_in(col_in),
    .row_out(row_out), .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_pressed(key_pressed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column to a driven-low row.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int n, input logic [15:0] mask, input bit ae, input bit aa,
                     input logic v, input logic [3:0] c, input logic p, input logic o);
    vec_t e;
    e.mask = mask; e.ack_eval = ae; e.ack_after = aa; e.v = v; e.c = c; e.p = p; e.o = o;
    for (int i = 0; i < n; i++) vecs.push_back(e);
  endtask

  task automatic model_clear_scan();
    m_prev = -1; m_cnt = 0; m_stable = -1; m_pressed = 1'b0;
  endtask

  task automatic model_frame(input logic [15:0] mask, input bit ack_eval);
    int  cand, idx;
    bit  ev, ack;
    idx = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
    cand = ($countones(mask) == 1) ? idx : -1;
    if (cand == m_prev) m_cnt = (m_cnt + 1 > DB) ? DB : m_cnt + 1;
    else m_cnt = 1;
    m_prev = cand;
    ev = 1'b0;
    if (m_cnt == DB && cand != m_stable) begin
      m_stable  = cand;
      m_pressed = (cand >= 0);
      ev        = (cand >= 0);
    end
    ack = ack_eval && m_valid;
    if (ev) begin
      if (!m_valid || ack) begin m_code = 4'(cand); m_valid = 1'b1; m_ovr = 1'b0; end
      else m_ovr = 1'b1;
    end else if (ack) begin
      m_valid = 1'b0; m_ovr = 1'b0;
    end
  endtask

  task automatic model_ack();
    if (m_valid) begin m_valid = 1'b0; m_ovr = 1'b0; end
  endtask

  task automatic run_frame(input logic [15:0] mask, input bit ack_eval);
    logic [3:0] exp_row;
    keys = mask;
    repeat (4) @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      exp_row = ~(4'b0001 << r);
      chk("row_out", {28'd0, row_out}, {28'd0, exp_row});
      scan_tick = 1'b1;
      @(negedge clk);
      scan_tick = 1'b0;
      if (r == 3 && ack_eval) key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      repeat (TP - 3) @(negedge clk);
    end
    model_frame(mask, ack_eval);
  endtask

  task automatic pulse_ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    model_ack();
    chk("ack_valid_clr", {31'd0, key_valid}, 32'd0);
    chk("ack_ovr_clr", {31'd0, overrun}, 32'd0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, {31'd0, key_valid}, {31'd0, m_valid});
    chk({tag, "_code"}, {28'd0, key_code}, {28'd0, m_code});
    chk({tag, "_pressed"}, {31'd0, key_pressed}, {31'd0, m_pressed});
    chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  task automatic en_off(input bit do_ack);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_row", {28'd0, row_out}, 32'hF);
    chk("en_off_pressed", {31'd0, key_pressed}, 32'd0);
    chk("en_off_valid_kept", {31'd0, key_valid}, {31'd0, m_valid});
    chk("en_off_code_kept", {28'd0, key_code}, {28'd0, m_code});
    if (do_ack) pulse_ack();
    en = 1'b1;
    model_clear_scan();
    @(negedge clk);
  endtask

  localparam logic [15:0] K0 = 16'h0001, K3 = 16'h0008, K5 = 16'h0020, K6 = 16'h0040;
  localparam logic [15:0] K7 = 16'h0080, K9 = 16'h0200, K12 = 16'h1000;

  initial begin
    logic [15:0] cur;
    int sel, a, b;

    // Directed table: {mask, ack at EVAL, ack after frame, valid, code, pressed, overrun}.
    add(5, 16'h0, 0, 0, 0, 0, 0, 0);
    add(2, K9, 0, 0, 0, 0, 0, 0);   add(1, K9, 0, 1, 1, 9, 1, 0);
    add(2, 16'h0, 0, 0, 0, 9, 1, 0); add(1, 16'h0, 0, 0, 0, 9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      add(1, K9, 0, 0, 0, 9, 0, 0); add(1, 16'h0, 0, 0, 0, 9, 0, 0);
    end
    add(2, K9, 0, 0, 0, 9, 0, 0);   add(1, K9, 0, 1, 1, 9, 1, 0);
    add(2, 16'h0, 0, 0, 0, 9, 1, 0); add(1, 16'h0, 0, 0, 0, 9, 0, 0);
    add(3, K0 | K5, 0, 0, 0, 9, 0, 0);
    add(2, K0, 0, 0, 0, 9, 0, 0);   add(1, K0, 0, 1, 1, 0, 1, 0);
    add(2, 16'h0, 0, 0, 0, 0, 1, 0); add(1, 16'h0, 0, 0, 0, 0, 0, 0);
    add(2, K3, 0, 0, 0, 0, 0, 0);   add(1, K3, 0, 0, 1, 3, 1, 0);
    add(2, 16'h0, 0, 0, 1, 3, 1, 0); add(1, 16'h0, 0, 0, 1, 3, 0, 0);
    add(2, K12, 0, 0, 1, 3, 0, 0);  add(1, K12, 0, 1, 1, 3, 1, 1);
    add(2, 16'h0, 0, 0, 0, 3, 1, 0); add(1, 16'h0, 0, 1, 0, 3, 0, 0);
    add(2, K5, 0, 0, 0, 3, 0, 0);   add(1, K5, 0, 1, 1, 5, 1, 0);
    add(2, K6, 0, 0, 0, 5, 1, 0);   add(1, K6, 0, 1, 1, 6, 1, 0);
    add(2, 16'h0, 0, 0, 0, 6, 1, 0); add(1, 16'h0, 0, 0, 0, 6, 0, 0);
    add(2, K3, 0, 0, 0, 6, 0, 0);   add(1, K3, 0, 0, 1, 3, 1, 0);
    add(2, 16'h0, 0, 0, 1, 3, 1, 0); add(1, 16'h0, 0, 0, 1, 3, 0, 0);
    add(2, K12, 0, 0, 1, 3, 0, 0);  add(1, K12, 0, 0, 1, 3, 1, 1);
    add(2, 16'h0, 0, 0, 1, 3, 1, 1); add(1, 16'h0, 0, 0, 1, 3, 0, 1);
    add(2, K7, 0, 0, 1, 3, 0, 1);   add(1, K7, 1, 1, 1, 7, 1, 0);
    add(2, 16'h0, 0, 0, 0, 7, 1, 0); add(1, 16'h0, 0, 0, 0, 7, 0, 0);

    rst_n = 1'b0; en = 1'b0; scan_tick = 1'b0; key_ack = 1'b0; keys = 16'h0;
    m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'd0;
    model_clear_scan();
    repeat (3) @(negedge clk);
    chk("rst_row", {28'd0, row_out}, 32'hE);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_pressed", {31'd0, key_pressed}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      run_frame(vecs[i].mask, vecs[i].ack_eval);
      chk($sformatf("vec%0d_valid", i), {31'd0, key_valid}, {31'd0, vecs[i].v});
      chk($sformatf("vec%0d_code", i), {28'd0, key_code}, {28'd0, vecs[i].c});
      chk($sformatf("vec%0d_pressed", i), {31'd0, key_pressed}, {31'd0, vecs[i].p});
      chk($sformatf("vec%0d_overrun", i), {31'd0, overrun}, {31'd0, vecs[i].o});
      if (vecs[i].ack_after) pulse_ack();
    end

    // Disable with an event pending: it survives, scan state does not.
    for (int i = 0; i < 3; i++) run_frame(K9, 0);
    chk("en_pre_valid", {31'd0, key_valid}, 32'd1);
    chk("en_pre_code", {28'd0, key_code}, 32'd9);
    en_off(0);
    for (int i = 0; i < 3; i++) run_frame(K9, 0);
    chk("en_re_overrun", {31'd0, overrun}, 32'd1);
    chk("en_re_code", {28'd0, key_code}, 32'd9);
    chk("en_re_pressed", {31'd0, key_pressed}, 32'd1);
    pulse_ack();
    for (int i = 0; i < 3; i++) run_frame(16'h0, 0);
    check_model("en_seq");

    // Randomised frames against the model.
    cur = 16'h0;
    for (int f = 0; f < 150; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 6) cur = 16'h0;
      else if (sel == 7 || sel == 8) begin
        a = $urandom_range(0, 15); cur = 16'h0; cur[a] = 1'b1;
      end else if (sel == 9) begin
        a = $urandom_range(0, 15); b = $urandom_range(0, 15);
        cur = 16'h0; cur[a] = 1'b1; cur[b] = 1'b1;
      end
      run_frame(cur, ($urandom_range(0, 7) == 0));
      check_model($sformatf("rnd%0d", f));
      if ($urandom_range(0, 2) == 0) pulse_ack();
      if ($urandom_range(0, 24) == 0) en_off($urandom_range(0, 1) == 1);
    end

    // Asynchronous reset in the middle of a frame with an event pending.
    for (int i = 0; i < 3; i++) run_frame(K9, 0);
    keys = K9;
    repeat (4) @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      scan_tick = 1'b1;
      @(negedge clk);
      scan_tick = 1'b0;
      repeat (TP - 1) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_row", {28'd0, row_out}, 32'hE);
    chk("arst_code", {28'd0, key_code}, 32'd0);
    chk("arst_valid", {31'd0, key_valid}, 32'd0);
    chk("arst_pressed", {31'd0, key_pressed}, 32'd0);
    chk("arst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0; m_ovr = 1'b0; m_code = 4'd0;
    model_clear_scan();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) run_frame(K9, 0);
    check_model("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
